cs_sample_feeder: RTL
=====================

// Module: cs_sample_feeder
// PURPOSE
//  Source side of the CS computational-system interface. It buffers 8-bit samples from an upstream
//  valid/ready producer in a FIFO and drives X and the CS reset (cs_reset) one sample per clock.
//  It restarts the CS window whenever the stream stalls, then captures Y and marks the full-window results.
//  Sits between the sample producer and CS; its results go to downstream result logic.
// PARAMETERS
//  DATA_W  8   sample width (X)
//  Y_W     10  CS result width (Y)
//  DEPTH   16  FIFO entries, power of two
//  WIN     9   CS window length, in samples
// PORTS
//  clk       in   1       clock; all state on rising edge
//  reset     in   1       synchronous, active-high reset
//  start     in   1       1-cycle pulse: begin streaming
//  stop      in   1       1-cycle pulse: end streaming; stop takes priority over start
//  in_data   in   DATA_W  producer sample
//  in_valid  in   1       producer data valid
//  in_ready  out  1       FIFO can accept a sample
//  X         out  DATA_W  sample to CS
//  cs_reset  out  1       reset to CS (primes CS window with X)
//  Y_in      in   Y_W     CS result; CS updates it on the falling clock edge
//  y_out     out  Y_W     captured full-window result
//  y_valid   out  1       y_out holds a new full-window result this cycle
//  underrun  out  1       sticky: stream stalled while STREAM; clears on reset or start
//  busy      out  1       state != IDLE
// BEHAVIOUR
//  Reset: FIFO flushed, state=IDLE, win_cnt=0, y_out=0, y_valid=0, underrun=0, in_ready=1.
//  FIFO: push when in_valid && in_ready; in_ready = !full (registered count).
//   Push and pop in the same cycle: both occur, count unchanged.
//   X is driven combinationally from the registered FIFO head.
//  FSM:
//   IDLE:   cs_reset=1, X=0, no pop. start && !stop -> WAIT; underrun cleared.
//   WAIT:   cs_reset=1. If FIFO non-empty: pop, X=head (CS primes with it), win_cnt=1 -> STREAM.
//           If empty: X=0, stay.
//   STREAM: if non-empty: pop, cs_reset=0, X=head, win_cnt=min(win_cnt+1,WIN).
//           If empty: cs_reset=1, X=0, underrun<=1, win_cnt=0 -> WAIT; the window restarts.
//   stop in any state -> IDLE next cycle, with cs_reset=1 and no pop that cycle; FIFO contents retained.
//  Result capture, latency 2:
//   Sample n is popped in cycle C with win_cnt after the pop == WIN (window full).
//   pop_full_d <= that condition. At the end of C+1, y_out<=Y_in and y_valid<=pop_full_d.
//   Result is visible in C+2; otherwise y_valid=0 and y_out holds.
//   Y_in is sampled only at the rising edge, after CS's falling-edge update.
//  Sustained stream: y_valid is high every cycle after the first WIN-1 samples of each window restart.
//  Reset mid-stream: aborts immediately. A pending pop_full_d is discarded; y_valid=0 next cycle.
//  Widths: win_cnt is $clog2(WIN+1) bits and saturates at WIN. FIFO pointers wrap modulo DEPTH.
// STRUCTURE
//  Package cs_pkg: DATA_W, Y_W, WIN constants; state enum {IDLE,WAIT,STREAM}.
//  Sub-module cs_sync_fifo (DEPTH x DATA_W, registered count, full/empty flags).
//  FSM, window counter and result capture live in the top module.
// TESTING
//  1. Push 9 x 50, start -> cs_reset high 1 cycle with X=50. Eight non-reset cycles follow.
//     y_valid once, 2 cycles after the 9th pop, y_out=112.
//  2. Push 1..9 then 10, start -> first y_out=11. Second y_valid on the next cycle, value from CS.
//     y_valid high 2 consecutive cycles.
//  3. Push 5 samples, start, wait -> underrun=1, state WAIT, cs_reset=1, no y_valid.
//     Then push 9 x 50 -> re-prime, y_out=112.
//  4. Fill 16 without start -> in_ready=0. Further in_valid is ignored; count stays 16.
//     Start -> in_ready=1 the cycle after the first pop.
//  5. Mid-stream stop && start same cycle -> IDLE, cs_reset=1, no pop. FIFO count unchanged.
//  6. Assert reset during STREAM with pop_full_d=1 -> y_valid=0 next cycle. FIFO empty, underrun=0, y_out=0.

Source files
------------

// File: rtl/cs_sample_feeder_pkg.sv
// Shared constants and state encoding for the CS sample feeder.
package cs_pkg;

    localparam int DATA_W = 8;
    localparam int Y_W    = 10;
    localparam int WIN    = 9;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        STREAM = 2'd2
    } cs_state_e;

endpackage

// File: rtl/cs_sample_feeder_if.sv
// Producer stream, CS drive/return and result signals of the sample feeder.
interface cs_sample_feeder_if;
    import cs_pkg::*;

    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] X;
    logic              cs_reset;
    logic [Y_W-1:0]    Y_in;
    logic [Y_W-1:0]    y_out;
    logic              y_valid;

    modport slave (
        input  in_data, in_valid, Y_in,
        output in_ready, X, cs_reset, y_out, y_valid
    );

    modport master (
        output in_data, in_valid, Y_in,
        input  in_ready, X, cs_reset, y_out, y_valid
    );

endinterface

// File: rtl/cs_sample_feeder_fifo.sv
// Synchronous FIFO with registered occupancy count; callers pass pre-qualified push/pop.
module cs_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [W-1:0]             wdata,
    input  logic                     pop,
    output logic [W-1:0]             rdata,
    output logic [$clog2(DEPTH):0]   count
);
    import cs_pkg::*;

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    assign rdata = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= wdata;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cs_sample_feeder.sv
// Feeds buffered samples to CS one per clock, restarts the window on stalls,
// and captures full-window CS results two cycles after the completing pop.
module cs_sample_feeder #(
    parameter int DEPTH = 16,
    parameter int WIN   = 9
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                stop,
    cs_sample_feeder_if.slave   bus,
    output logic                underrun,
    output logic                busy
);
    import cs_pkg::*;

    localparam int WCW = $clog2(WIN + 1);
    localparam int CW  = $clog2(DEPTH) + 1;

    localparam logic [1:0] ST_IDLE   = IDLE;
    localparam logic [1:0] ST_WAIT   = WAIT;
    localparam logic [1:0] ST_STREAM = STREAM;

    logic [1:0]        state, state_nxt;
    logic [WCW-1:0]    win_cnt, win_nxt;
    logic [CW-1:0]     fifo_cnt;
    logic [DATA_W-1:0] head;
    logic              fifo_full, fifo_empty;
    logic              push, pop, pop_full, pop_full_d;
    logic              set_underrun;
    logic [DATA_W-1:0] x_drv;
    logic              cs_rst_drv;
    logic [Y_W-1:0]    y_out_q;
    logic              y_valid_q;

    assign fifo_full  = (fifo_cnt == CW'(DEPTH));
    assign fifo_empty = (fifo_cnt == '0);
    assign push       = bus.in_valid && !fifo_full;

    cs_sync_fifo #(.DEPTH(DEPTH), .W(DATA_W)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata (bus.in_data),
        .pop   (pop),
        .rdata (head),
        .count (fifo_cnt)
    );

    always_comb begin
        state_nxt    = state;
        win_nxt      = win_cnt;
        pop          = 1'b0;
        cs_rst_drv   = 1'b1;
        x_drv        = '0;
        set_underrun = 1'b0;
        if (stop) begin
            state_nxt = ST_IDLE;
            win_nxt   = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    win_nxt = '0;
                    if (start) state_nxt = ST_WAIT;
                end
                // First sample primes the CS window while cs_reset is still high.
                ST_WAIT: begin
                    if (!fifo_empty) begin
                        pop       = 1'b1;
                        x_drv     = head;
                        win_nxt   = WCW'(1);
                        state_nxt = ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        cs_rst_drv = 1'b0;
                        x_drv      = head;
                        win_nxt    = (win_cnt == WCW'(WIN)) ? win_cnt : win_cnt + 1'b1;
                    end else begin
                        set_underrun = 1'b1;
                        win_nxt      = '0;
                        state_nxt    = ST_WAIT;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    win_nxt   = '0;
                end
            endcase
        end
    end

    assign pop_full = pop && (win_nxt == WCW'(WIN));

    // Y_in reflects the window one CS update behind X, hence the extra stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            win_cnt    <= '0;
            pop_full_d <= 1'b0;
            y_valid_q  <= 1'b0;
            y_out_q    <= '0;
            underrun   <= 1'b0;
        end else begin
            state      <= state_nxt;
            win_cnt    <= win_nxt;
            pop_full_d <= pop_full;
            y_valid_q  <= pop_full_d;
            if (pop_full_d)
                y_out_q <= bus.Y_in;
            if (state == ST_IDLE && start && !stop)
                underrun <= 1'b0;
            else if (set_underrun)
                underrun <= 1'b1;
        end
    end

    assign bus.in_ready = !fifo_full;
    assign bus.X        = x_drv;
    assign bus.cs_reset = cs_rst_drv;
    assign bus.y_out    = y_out_q;
    assign bus.y_valid  = y_valid_q;
    assign busy         = (state != ST_IDLE);

endmodule
